result_collector: RTL and testbench

- Receive end of the training-data stream into the DRP sparse network.
- Takes the network's output-layer activations chunk-by-chunk, in the same slicing and cycle-block order that the data feed uses for ideal outputs `y`.
- Reassembles each sample, computes argmax, and checks it against the one-hot ideal output.
- Keeps running totals of trials and correct classifications for training-accuracy monitoring.

---
 rtl/result_collector.sv | 160 ++++++++++++++++
 tb/tb_result_collector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector
//   Receive end of the training-data stream. Output-layer activations arrive
//   chunk by chunk (cpc-2 chunks per sample, z = out/(cpc-2) neurons each).
//   The block tracks the running argmax over the chunks of a sample and the
//   ideal-output bit at that position. After the last chunk it publishes the
//   predicted index and whether it was correct. It also keeps saturating
//   totals of trials and correct classifications.
//
// Ports
//   clk          clock
//   reset        asynchronous active-high reset
//   clear        synchronous clear of counters and in-progress sample
//   a_valid      a_in / y_in carry a chunk this clock
//   a_in         z unsigned activations, lane j = bits [j*width +: width]
//   y_in         z ideal output bits, lane j = bit j
//   result_valid one-clock pulse when a sample result is published
//   pred         argmax neuron index of the last completed sample
//   correct      ideal bit at pred of the last completed sample
//   total        completed samples since reset/clear (saturating)
//   num_correct  correct samples since reset/clear (saturating)
module result_collector #(
    parameter int cpc   = 6,
    parameter int out   = 4,
    parameter int width = 16,
    parameter int cnt_w = 16,
    localparam int CHUNKS = cpc - 2,
    localparam int Z      = out / CHUNKS,
    localparam int PW     = (out > 1) ? $clog2(out) : 1,
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 a_valid,
    input  logic [Z*width-1:0]   a_in,
    input  logic [Z-1:0]         y_in,
    output logic                 result_valid,
    output logic [PW-1:0]        pred,
    output logic                 correct,
    output logic [cnt_w-1:0]     total,
    output logic [cnt_w-1:0]     num_correct
);

    function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] c,
                                                 input logic inc);
        if (inc && (c != {cnt_w{1'b1}}))
            return c + 1'b1;
        return c;
    endfunction

    logic [KW-1:0]    k_q, k_d;
    logic [width-1:0] run_max_q, run_max_d;
    logic [PW-1:0]    run_idx_q, run_idx_d;
    logic             run_lab_q, run_lab_d;
    logic             result_valid_q, result_valid_d;
    logic [PW-1:0]    pred_q, pred_d;
    logic             correct_q, correct_d;
    logic [cnt_w-1:0] total_q, total_d;
    logic [cnt_w-1:0] num_correct_q, num_correct_d;

    // Per-chunk argmax; strict > keeps the lowest lane on ties.
    logic [width-1:0] chunk_max;
    logic [PW-1:0]    chunk_lane;
    logic             chunk_lab;

    always_comb begin
        chunk_max  = a_in[0 +: width];
        chunk_lane = '0;
        chunk_lab  = y_in[0];
        for (int j = 1; j < Z; j++) begin
            if (a_in[j*width +: width] > chunk_max) begin
                chunk_max  = a_in[j*width +: width];
                chunk_lane = PW'(j);
                chunk_lab  = y_in[j];
            end
        end
    end

    logic             take;
    logic             last;
    logic [width-1:0] m_max;
    logic [PW-1:0]    m_idx;
    logic             m_lab;

    always_comb begin
        // Chunk 0 always loads; later chunks only win on a strictly larger max.
        take  = (k_q == '0) || (chunk_max > run_max_q);
        last  = (k_q == KW'(CHUNKS - 1));
        m_max = take ? chunk_max : run_max_q;
        m_idx = take ? (PW'(k_q) * PW'(Z) + chunk_lane) : run_idx_q;
        m_lab = take ? chunk_lab : run_lab_q;
    end

    always_comb begin
        k_d            = k_q;
        run_max_d      = run_max_q;
        run_idx_d      = run_idx_q;
        run_lab_d      = run_lab_q;
        result_valid_d = 1'b0;
        pred_d         = pred_q;
        correct_d      = correct_q;
        total_d        = total_q;
        num_correct_d  = num_correct_q;

        if (clear) begin
            // Clear beats a_valid: the chunk is dropped, pred/correct hold.
            k_d           = '0;
            run_max_d     = '0;
            run_idx_d     = '0;
            run_lab_d     = 1'b0;
            total_d       = '0;
            num_correct_d = '0;
        end else if (a_valid) begin
            run_max_d = m_max;
            run_idx_d = m_idx;
            run_lab_d = m_lab;
            if (last) begin
                k_d            = '0;
                result_valid_d = 1'b1;
                pred_d         = m_idx;
                correct_d      = m_lab;
                total_d        = sat_inc(total_q, 1'b1);
                num_correct_d  = sat_inc(num_correct_q, m_lab);
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q            <= '0;
            run_max_q      <= '0;
            run_idx_q      <= '0;
            run_lab_q      <= 1'b0;
            result_valid_q <= 1'b0;
            pred_q         <= '0;
            correct_q      <= 1'b0;
            total_q        <= '0;
            num_correct_q  <= '0;
        end else begin
            k_q            <= k_d;
            run_max_q      <= run_max_d;
            run_idx_q      <= run_idx_d;
            run_lab_q      <= run_lab_d;
            result_valid_q <= result_valid_d;
            pred_q         <= pred_d;
            correct_q      <= correct_d;
            total_q        <= total_d;
            num_correct_q  <= num_correct_d;
        end
    end

    assign result_valid = result_valid_q;
    assign pred         = pred_q;
    assign correct      = correct_q;
    assign total        = total_q;
    assign num_correct  = num_correct_q;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    localparam int CPC = 6;
    localparam int OUT = 4;
    localparam int W   = 16;
    localparam int CH  = CPC - 2;
    localparam int Z   = OUT / CH;
    localparam int PW  = 2;
    localparam int MAXA = 65535;
    localparam int MAXS = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              a_valid;
    logic [Z*W-1:0]    a_in;
    logic [Z-1:0]      y_in;

    logic              rv_a, cor_a;
    logic [PW-1:0]     pred_a;
    logic [15:0]       tot_a, nc_a;
    logic              rv_s, cor_s;
    logic [PW-1:0]     pred_s;
    logic [2:0]        tot_s, nc_s;

    result_collector #(.cpc(CPC), .out(OUT), .width(W), .cnt_w(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .a_valid(a_valid),
        .a_in(a_in), .y_in(y_in), .result_valid(rv_a), .pred(pred_a),
        .correct(cor_a), .total(tot_a), .num_correct(nc_a)
    );

    result_collector #(.cpc(CPC), .out(OUT), .width(W), .cnt_w(3)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .a_valid(a_valid),
        .a_in(a_in), .y_in(y_in), .result_valid(rv_s), .pred(pred_s),
        .correct(cor_s), .total(tot_s), .num_correct(nc_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int cyc;
        int pred;
        bit cor;
        int tot;
        int nc;
        int tots;
        int ncs;
    } exp_t;

    exp_t q[$];

    // Reference model: whole-sample storage, argmax taken once at the end.
    int mk;
    int vals[OUT];
    bit yb[OUT];
    int m_tot, m_nc, m_tots, m_ncs;
    int last_pred;
    bit last_cor;
    int ca[Z];
    bit cy[Z];
    int sa[OUT];
    bit sy[OUT];

    task automatic model_reset();
        mk = 0; m_tot = 0; m_nc = 0; m_tots = 0; m_ncs = 0;
        last_pred = 0; last_cor = 0;
        q.delete();
    endtask

    task automatic publish();
        exp_t e;
        int best;
        best = 0;
        for (int i = 1; i < OUT; i++)
            if (vals[i] > vals[best]) best = i;
        last_pred = best;
        last_cor  = yb[best];
        if (m_tot < MAXA) m_tot++;
        if (last_cor && m_nc < MAXA) m_nc++;
        if (m_tots < MAXS) m_tots++;
        if (last_cor && m_ncs < MAXS) m_ncs++;
        e.cyc = cyc + 1; e.pred = best; e.cor = last_cor;
        e.tot = m_tot; e.nc = m_nc; e.tots = m_tots; e.ncs = m_ncs;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input bit clr);
        a_valid = v;
        clear   = clr;
        for (int j = 0; j < Z; j++) begin
            a_in[j*W +: W] = ca[j][W-1:0];
            y_in[j]        = cy[j];
        end
        if (clr) begin
            mk = 0; m_tot = 0; m_nc = 0; m_tots = 0; m_ncs = 0;
        end else if (v) begin
            for (int j = 0; j < Z; j++) begin
                vals[mk*Z+j] = ca[j];
                yb[mk*Z+j]   = cy[j];
            end
            mk++;
            if (mk == CH) begin
                publish();
                mk = 0;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            a_valid = 1'b0;
            clear   = 1'b0;
            a_in    = Z*W'($urandom);
            y_in    = Z'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_sample(input int gap);
        for (int k = 0; k < CH; k++) begin
            for (int j = 0; j < Z; j++) begin
                ca[j] = sa[k*Z+j];
                cy[j] = sy[k*Z+j];
            end
            drive(1'b1, 1'b0);
            if (k < CH - 1) idle(gap);
        end
    endtask

    task automatic rand_chunk();
        for (int j = 0; j < Z; j++) begin
            ca[j] = $urandom_range(0, 7);
            cy[j] = 1'($urandom);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rv"},   rv_a,   0);
        check({tag, "_pred"}, pred_a, 0);
        check({tag, "_cor"},  cor_a,  0);
        check({tag, "_tot"},  tot_a,  0);
        check({tag, "_nc"},   nc_a,   0);
        check({tag, "_tots"}, tot_s,  0);
    endtask

    // Assert reset between edges and look at the outputs before any edge.
    task automatic do_reset();
        idle(1);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_tot"},  tot_a, m_tot);
        check({tag, "_nc"},   nc_a,  m_nc);
        check({tag, "_tots"}, tot_s, m_tots);
        check({tag, "_ncs"},  nc_s,  m_ncs);
        check({tag, "_pred"}, pred_a, last_pred);
        check({tag, "_cor"},  cor_a,  last_cor);
    endtask

    // Monitor: compares every published result against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            bit exp_pulse;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_result: expected pulse at cycle %0d, now %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            exp_pulse = (q.size() > 0) && (q[0].cyc == cyc);
            check("result_valid", rv_a, exp_pulse);
            check("result_valid_s", rv_s, exp_pulse);
            if (exp_pulse) begin
                exp_t e;
                e = q.pop_front();
                check("pred",          pred_a, e.pred);
                check("correct",       cor_a,  e.cor);
                check("total",         tot_a,  e.tot);
                check("num_correct",   nc_a,   e.nc);
                check("pred_s",        pred_s, e.pred);
                check("total_s",       tot_s,  e.tots);
                check("num_correct_s", nc_s,   e.ncs);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_pred;
        int best;
        reset = 1'b1; clear = 1'b0; a_valid = 1'b0; a_in = '0; y_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        reset = 1'b0;
        idle(2);

        // Reset mid-sample discards the partial sample.
        rand_chunk(); drive(1'b1, 1'b0);
        rand_chunk(); drive(1'b1, 1'b0);
        do_reset();
        for (int k = 0; k < CH; k++) begin rand_chunk(); drive(1'b1, 1'b0); end
        idle(2);
        check("midreset_total", tot_a, 1);

        // Basic sample, directed expectation.
        do_reset();
        sa = '{10, 50, 20, 5}; sy = '{0, 1, 0, 0};
        send_sample(0);
        idle(2);
        check("basic_pred", pred_a, 1);
        check("basic_cor",  cor_a,  1);
        check("basic_tot",  tot_a,  1);
        check("basic_nc",   nc_a,   1);

        // Tie: earlier chunk wins.
        do_reset();
        sa = '{30, 30, 0, 0}; sy = '{0, 1, 0, 0};
        send_sample(0);
        idle(2);
        check("tie_pred", pred_a, 0);
        check("tie_cor",  cor_a,  0);
        check("tie_tot",  tot_a,  1);
        check("tie_nc",   nc_a,   0);

        // Gaps between chunks.
        do_reset();
        sa = '{10, 50, 20, 5}; sy = '{0, 1, 0, 0};
        send_sample(3);
        idle(2);
        check("gap_pred", pred_a, 1);
        check("gap_cor",  cor_a,  1);
        check("gap_tot",  tot_a,  1);

        // Back-to-back samples over consecutive valid clocks.
        do_reset();
        for (int k = 0; k < 2*CH; k++) begin rand_chunk(); drive(1'b1, 1'b0); end
        idle(2);
        check("b2b_tot", tot_a, 2);
        check_counts("b2b");

        // Saturation on the narrow counter instance.
        do_reset();
        for (int s = 0; s < 9; s++) begin
            for (int i = 0; i < OUT; i++) sa[i] = $urandom_range(0, 100);
            best = 0;
            for (int i = 1; i < OUT; i++) if (sa[i] > sa[best]) best = i;
            for (int i = 0; i < OUT; i++) sy[i] = (i == best);
            send_sample($urandom_range(0, 1));
        end
        idle(2);
        check("sat_tots", tot_s, 7);
        check("sat_ncs",  nc_s,  7);
        check("sat_tot",  tot_a, 9);
        check("sat_nc",   nc_a,  9);
        saved_pred = last_pred;
        rand_chunk(); drive(1'b1, 1'b1);
        idle(1);
        check("clear_tots", tot_s, 0);
        check("clear_ncs",  nc_s,  0);
        check("clear_tot",  tot_a, 0);
        check("clear_pred", pred_a, saved_pred);

        // Clear coincident with the last chunk drops the sample.
        do_reset();
        for (int k = 0; k < CH - 1; k++) begin rand_chunk(); drive(1'b1, 1'b0); end
        rand_chunk(); drive(1'b1, 1'b1);
        idle(3);
        check("clrlast_tot", tot_a, 0);
        for (int k = 0; k < CH; k++) begin rand_chunk(); drive(1'b1, 1'b0); end
        idle(2);
        check("clrlast_next_tot", tot_a, 1);

        // Randomized traffic with small values (frequent ties), gaps and clears.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rand_chunk();
            if ($urandom_range(0, 39) == 0)
                drive(1'($urandom), 1'b1);
            else
                drive(1'b1, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        check_counts("random_end");
        check("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
